ula_sequencial: RTL and testbench

Parametrised, registered successor of the 4-bit combinational ALU/display path. It executes one of eight operations on WIDTH-bit operands, or on the internal accumulator, and stores the result and status flags. It then converts the result to packed BCD over WIDTH cycles using a shift-add-3 sequencer. Sits between the board switch/key debouncers and the per-digit `decodificador_7seg` instances.

---
 rtl/ula_pkg.sv | 32 +++
 rtl/ula_sequencial_if.sv | 32 +++
 rtl/bcd_sequencial.sv | 61 ++++++
 rtl/ula_sequencial.sv | 162 ++++++++++++++++
 tb/tb_ula_sequencial.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared op codes, FSM state type and BCD sizing helper for ula_sequencial.
package ula_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_AND   = 3'b010;
  localparam logic [OP_W-1:0] OP_OR    = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_LOADB = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL   = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR   = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  // Smallest digit count whose decimal range covers 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned maxv;
    longint unsigned p;
    int d;
    maxv = (64'd1 << width) - 64'd1;
    p = 1;
    d = 0;
    while (p <= maxv) begin
      p = p * 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/ula_sequencial_if.sv
// Request/result bundle between the board input logic and ula_sequencial.
interface ula_sequencial_if
  import ula_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic              start;
  logic [OP_W-1:0]   op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              use_acc;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [4*DIGITS-1:0] bcd;
  logic              carry;
  logic              overflow;
  logic              zero;
  logic              negative;

  modport master (
    output start, op, a, b, cin, use_acc,
    input  busy, done, result, bcd, carry, overflow, zero, negative
  );

  modport slave (
    input  start, op, a, b, cin, use_acc,
    output busy, done, result, bcd, carry, overflow, zero, negative
  );
endinterface

// File: rtl/bcd_sequencial.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per clock, WIDTH steps.
module bcd_sequencial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] bin_sh;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_nxt;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    adj      = add3(work);
    work_nxt = BW'({adj, bin_sh[WIDTH-1]});
  end

  // The output register only moves on the final step, so it holds the previous value meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      bcd      <= '0;
    end else if (load) begin
      step_cnt <= CW'(WIDTH);
    end else if (step_cnt != '0) begin
      step_cnt <= step_cnt - CW'(1);
      if (step_cnt == CW'(1)) bcd <= work_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      bin_sh <= bin;
      work   <= '0;
    end else if (step_cnt != '0) begin
      bin_sh <= {bin_sh[WIDTH-2:0], 1'b0};
      work   <= work_nxt;
    end
  end

  assign busy = (step_cnt != '0);

endmodule

// File: rtl/ula_sequencial.sv
// Registered ALU with accumulator and sequential BCD output stage.
// Status flags are built only when ULA_FLAGS_EN is defined; otherwise they read 0.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic             clk,
  input logic             rst_n,
  ula_sequencial_if.slave bus
);
  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  if (WIDTH < 2 || DIGITS < min_digits(WIDTH)) begin : g_param_check
    $error("ula_sequencial: WIDTH must be >= 2 and DIGITS must cover 2^WIDTH-1");
  end

  state_t           state;
  logic [CW-1:0]    conv_cnt;
  logic [WIDTH-1:0] acc;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             use_acc_q;

  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             conv_load;
  logic             conv_busy;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
  endfunction

  always_comb begin
    opa     = use_acc_q ? acc : a_q;
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum     = {1'b0, opa} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_ovf(opa, b_q, alu_res);
      end
      OP_SUB: begin
        sum     = {1'b0, opa} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_ovf(opa, ~b_q, alu_res);
      end
      OP_AND:   alu_res = opa & b_q;
      OP_OR:    alu_res = opa | b_q;
      OP_XOR:   alu_res = opa ^ b_q;
      OP_LOADB: alu_res = b_q;
      OP_SHL: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[MSB];
      end
      default: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      conv_cnt <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) state <= EXEC;
        EXEC: begin
          acc      <= alu_res;
          conv_cnt <= CW'(WIDTH - 1);
          state    <= CONV;
        end
        CONV: begin
          if (conv_cnt == '0) state <= DONE;
          else conv_cnt <= conv_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request operands are captured once so later input changes cannot disturb the operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_q      <= bus.op;
      a_q       <= bus.a;
      b_q       <= bus.b;
      cin_q     <= bus.cin;
      use_acc_q <= bus.use_acc;
    end
  end

  assign conv_load  = (state == EXEC);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = acc;

  bcd_sequencial #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .bin   (alu_res),
    .busy  (conv_busy),
    .bcd   (bus.bcd)
  );

`ifdef ULA_FLAGS_EN
  logic carry_q, ovf_q, zero_q, neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (state == EXEC) begin
      carry_q <= alu_c;
      ovf_q   <= alu_v;
      zero_q  <= (alu_res == '0);
      neg_q   <= alu_res[MSB];
    end
  end

  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;

  logic unused_conv;
  assign unused_conv = conv_busy;
`else
  logic unused_flags;
  assign unused_flags = ^{alu_c, alu_v, conv_busy};

  assign bus.carry    = 1'b0;
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
  assign bus.negative = 1'b0;
`endif

endmodule

// File: tb/tb_ula_sequencial.sv
// Bench for ula_sequencial: arithmetic reference model plus directed transactions.
`timescale 1ns/1ps
module tb_ula_sequencial;
  import ula_pkg::*;

  localparam int W = 8;
  localparam int D = 3;
  localparam int M = 1 << W;
`ifdef ULA_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_sequencial_if #(.WIDTH(W), .DIGITS(D)) bus ();

  ula_sequencial #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic void ref_alu(input int op, input int av, input int bv, input int ci,
                                  output int r, output bit c, output bit v);
    int sa, sb, s;
    sa = (av >= M/2) ? av - M : av;
    sb = (bv >= M/2) ? bv - M : bv;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      0: begin s = av + bv + ci; r = s % M; c = (s >= M);
               v = (sa + sb + ci > M/2 - 1) || (sa + sb + ci < -M/2); end
      1: begin s = av - bv; r = (s + M) % M; c = (av >= bv);
               v = (sa - sb > M/2 - 1) || (sa - sb < -M/2); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = bv;
      6: begin r = (av * 2) % M; c = (av >= M/2); end
      default: begin r = av / 2; c = ((av % 2) == 1); end
    endcase
  endfunction

  function automatic int to_bcd(input int v);
    int r, x;
    r = 0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r = r + ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Model timeline in posedge counts: accept at K, result at K+1, bcd/done at K+W+1.
  int cyc = 0;
  int m_busy_end = -10;
  int m_res_at = -1;
  int m_bcd_at = -1;
  int m_res = 0;
  int m_bcd = 0;
  bit m_c, m_v, m_z, m_n;
  int p_res;
  bit p_c, p_v, p_z, p_n;

  always @(posedge clk) begin
    int r;
    bit c, v;
    cyc++;
    if (!rst_n) begin
      m_busy_end = -10; m_res_at = -1; m_bcd_at = -1;
      m_res = 0; m_bcd = 0;
      m_c = 0; m_v = 0; m_z = 0; m_n = 0;
    end else begin
      if (cyc == m_res_at) begin
        m_res = p_res;
        m_c = p_c & FL_EN; m_v = p_v & FL_EN; m_z = p_z & FL_EN; m_n = p_n & FL_EN;
      end
      if (cyc == m_bcd_at) m_bcd = to_bcd(m_res);
      if (bus.start && (cyc - 1 > m_busy_end)) begin
        ref_alu(int'(bus.op), bus.use_acc ? m_res : int'(bus.a), int'(bus.b), int'(bus.cin), r, c, v);
        p_res = r; p_c = c; p_v = v; p_z = (r == 0); p_n = (r >= M/2);
        m_res_at   = cyc + 1;
        m_bcd_at   = cyc + W + 1;
        m_busy_end = cyc + W + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",     bus.busy,     cyc <= m_busy_end);
    chk("done",     bus.done,     cyc == m_busy_end);
    chk("result",   bus.result,   m_res);
    chk("bcd",      bus.bcd,      m_bcd);
    chk("carry",    bus.carry,    m_c);
    chk("overflow", bus.overflow, m_v);
    chk("zero",     bus.zero,     m_z);
    chk("negative", bus.negative, m_n);
  end

  task automatic run(input string nm, input logic [2:0] op, input int av, input int bv,
                     input bit ci, input bit ua, input int e_res,
                     input bit e_c, input bit e_v, input bit e_z, input bit e_n,
                     input logic [11:0] e_bcd);
    int n;
    @(negedge clk); #1;
    bus.op = op; bus.a = W'(av); bus.b = W'(bv); bus.cin = ci; bus.use_acc = ua;
    bus.start = 1'b1;
    @(negedge clk);
    n = 1;
    #1;
    bus.start = 1'b0;
    bus.op = op ^ 3'b101; bus.a = ~bus.a; bus.b = ~bus.b; bus.cin = ~ci;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"},  n, W + 2);
    chk({nm, "_result"},   bus.result, e_res);
    chk({nm, "_bcd"},      bus.bcd, e_bcd);
    chk({nm, "_carry"},    bus.carry, e_c & FL_EN);
    chk({nm, "_overflow"}, bus.overflow, e_v & FL_EN);
    chk({nm, "_zero"},     bus.zero, e_z & FL_EN);
    chk({nm, "_negative"}, bus.negative, e_n & FL_EN);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.use_acc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_bcd",    bus.bcd, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    #1 rst_n = 1'b1;

    //   name         op        a      b      cin ua  res  c  v  z  n  bcd
    run("add_wrap",  OP_ADD,   200,   100,   0,  0,  44, 1, 0, 0, 0, 12'h044);
    run("sub_neg",   OP_SUB,   5,     7,     0,  0, 254, 0, 0, 0, 1, 12'h254);
    run("add_ovf",   OP_ADD,   100,   100,   0,  0, 200, 0, 1, 0, 1, 12'h200);
    run("loadb",     OP_LOADB, 0,     250,   0,  0, 250, 0, 0, 0, 1, 12'h250);
    run("acc_add5",  OP_ADD,   0,     5,     0,  1, 255, 0, 0, 0, 1, 12'h255);
    run("acc_add1",  OP_ADD,   0,     1,     0,  1,   0, 1, 0, 1, 0, 12'h000);
    run("and",       OP_AND,   8'hF0, 8'h3C, 1,  0,  48, 0, 0, 0, 0, 12'h048);
    run("sub_cin",   OP_SUB,   9,     4,     1,  0,   5, 1, 0, 0, 0, 12'h005);
    run("add_cin",   OP_ADD,   1,     2,     1,  0,   4, 0, 0, 0, 0, 12'h004);
    run("xor",       OP_XOR,   8'hFF, 8'h0F, 0,  0, 240, 0, 0, 0, 1, 12'h240);
    run("or",        OP_OR,    8'h12, 8'h21, 0,  0,  51, 0, 0, 0, 0, 12'h051);
    run("shl",       OP_SHL,   8'hC1, 0,     0,  0, 130, 1, 0, 0, 1, 12'h130);

    // A start pulse during conversion must be dropped, not queued.
    @(negedge clk); #1;
    bus.op = OP_ADD; bus.a = 8'd3; bus.b = 8'd4; bus.cin = 1'b0; bus.use_acc = 1'b0;
    bus.start = 1'b1;
    dn = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
      #1;
      bus.start = (i == 4);
      if (i == 4) begin bus.op = OP_LOADB; bus.b = 8'd99; end
    end
    chk("busy_start_dones",  dn, 1);
    chk("busy_start_result", bus.result, 7);
    chk("busy_start_bcd",    bus.bcd, 12'h007);

    // Reset in the middle of a conversion aborts it without a done pulse.
    @(negedge clk); #1;
    bus.op = OP_ADD; bus.a = 8'd10; bus.b = 8'd20; bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_result", bus.result, 0);
    chk("abort_bcd",    bus.bcd, 0);
    chk("abort_busy",   bus.busy, 0);
    chk("abort_done",   bus.done, 0);
    chk("abort_carry",  bus.carry, 0);
    #1 rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("abort_no_done", dn, 0);

    run("shr",       OP_SHR,   8'h81, 0,     0,  0,  64, 1, 0, 0, 0, 12'h064);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
